// File: rtl/permutation_iter.sv
// -----------------------------------------------------------------------------
// permutation_iter
//
// Iterative ASCON permutation engine. It holds the 320-bit state register and
// applies one round per clock: constant addition (pC), the substitution layer
// (pS, the `substitution` module below), then linear diffusion (pL). The first
// round index selects the variant: 0 -> p12, 4 -> p8, 6 -> p6, and 12..15
// means zero rounds (the loaded state is handed back unchanged).
//
// Optional feature: define PERM_ABORT_EN to add the abort_i input.
//
// Ports:
//   clock_i        in   1        system clock, rising edge
//   reset_i        in   1        asynchronous, active-high reset
//   start_i        in   1        start request, sampled only in IDLE
//   round_start_i  in   4        first round index
//   state_i        in   5x64     state loaded on an accepted start
//   abort_i        in   1        (PERM_ABORT_EN only) abandon the current run
//   state_o        out  5x64     state register, always driven
//   busy_o         out  1        high whenever the FSM is not IDLE
//   done_o         out  1        one-cycle pulse marking a valid state_o
//
// Lane order: state[0] = x0 ... state[4] = x4.
//
// FSM visibility: {busy_o, done_o} encodes the FSM state exactly:
//   2'b00 = IDLE, 2'b10 = RUN, 2'b11 = DONE.
// -----------------------------------------------------------------------------

// Handshake: start_i is a level sampled only when busy_o is low; a high
// start_i at that edge is accepted and loads state_i/round_start_i. While
// busy_o is high start_i is ignored (no queueing). done_o is high for exactly
// one cycle, and state_o is valid in that cycle and stays valid until the next
// accepted start. A start held high through DONE is accepted one idle cycle
// after done_o.

// Combinational ASCON substitution layer, bitsliced over the 64 columns.
module substitution (
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;

    always_comb begin
        // input mixing
        a0 = state_i[0] ^ state_i[4];
        a1 = state_i[1];
        a2 = state_i[2] ^ state_i[1];
        a3 = state_i[3];
        a4 = state_i[4] ^ state_i[3];
        // chi-like nonlinear core
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        // output mixing
        state_o[0] = b0 ^ b4;
        state_o[1] = b1 ^ b0;
        state_o[2] = ~b2;
        state_o[3] = b3 ^ b2;
        state_o[4] = b4;
    end
endmodule

module permutation_iter #(
    parameter int NB_ROUNDS = 12
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       round_start_i,
    input  logic [4:0][63:0] state_i,
`ifdef PERM_ABORT_EN
    input  logic             abort_i,
`endif
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] LAST_RND = 4'(NB_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       cnt_q;
    logic [4:0][63:0] state_q;

    logic [4:0][63:0] after_pc;
    logic [4:0][63:0] after_ps;
    logic [4:0][63:0] after_pl;
    logic             start_runs;
    logic             abort_hit;

`ifdef PERM_ABORT_EN
    // Abort only matters while a run is in progress or being reported.
    assign abort_hit = abort_i && (fsm_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // A first index past the last table entry means zero rounds.
    assign start_runs = (int'({28'd0, round_start_i}) < NB_ROUNDS);

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // ---------------- round datapath ----------------
    always_comb begin
        after_pc       = state_q;
        after_pc[2][7:0] = state_q[2][7:0] ^ {~cnt_q, cnt_q};
    end

    substitution u_substitution (
        .state_i (after_pc),
        .state_o (after_ps)
    );

    always_comb begin
        after_pl[0] = after_ps[0] ^ ror(after_ps[0], 19) ^ ror(after_ps[0], 28);
        after_pl[1] = after_ps[1] ^ ror(after_ps[1], 61) ^ ror(after_ps[1], 39);
        after_pl[2] = after_ps[2] ^ ror(after_ps[2],  1) ^ ror(after_ps[2],  6);
        after_pl[3] = after_ps[3] ^ ror(after_ps[3], 10) ^ ror(after_ps[3], 17);
        after_pl[4] = after_ps[4] ^ ror(after_ps[4],  7) ^ ror(after_ps[4], 41);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    fsm_d = start_runs ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // The round with the last index is still applied on this edge.
                if (cnt_q == LAST_RND) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
        // Abort wins over every other transition, including the final round.
        if (abort_hit) begin
            fsm_d = S_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = (fsm_q != S_IDLE);
        done_o = (fsm_q == S_DONE);
    end

    // ---------------- state register and round counter ----------------
    // Outside a load or an active round the register holds, so IDLE keeps
    // showing the last result and an aborted run freezes where it stopped.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else if (fsm_q == S_IDLE && start_i) begin
            state_q <= state_i;
            cnt_q   <= round_start_i;
        end else if (fsm_q == S_RUN && !abort_hit) begin
            state_q <= after_pl;
            cnt_q   <= cnt_q + 4'd1;
        end
    end

    assign state_o = state_q;

endmodule
